pearson_hash_engine: RTL and testbench

//   Parametrised multi-lane Pearson hash engine. Consumes one MSG_BYTES-wide message
//   per valid/ready handshake and applies h <= T[h ^ byte] one byte per cycle.

---
 rtl/pearson_pkg.sv | 14 +
 rtl/pearson_lane.sv | 45 ++++
 rtl/pearson_hash_engine.sv | 161 ++++++++++++++++
 tb/tb_pearson_hash_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pearson_pkg.sv
// Shared types and constants for the Pearson hash engine.
package pearson_pkg;

  localparam int TBL_DEPTH = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pearson_lane.sv
// One Pearson hash lane: the running h register and its table lookup.
// h is loaded with the lane's initial value on accept, then stepped
// once per HASH cycle with h <= T[h ^ byte].
module pearson_lane
  import pearson_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic [7:0]             init_i,
  input  logic [7:0]             msg_byte_i,
  input  logic [8*TBL_DEPTH-1:0] tbl_i,
  output logic [7:0]             h_o
);

  byte_t h_q;
  byte_t h_d;
  byte_t idx_s;

  // Next h: load initial value, take one table step, or hold.
  always_comb begin
    idx_s = h_q ^ msg_byte_i;
    h_d   = h_q;
    if (load_i) begin
      h_d = init_i;
    end else if (step_i) begin
      h_d = tbl_i[{idx_s, 3'b000} +: 8];
    end else begin
      h_d = h_q;
    end
  end

  // h register; cleared by reset so an aborted hash leaves nothing behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= 8'h00;
    end else begin
      h_q <= h_d;
    end
  end

  assign h_o = h_q;

endmodule

// File: rtl/pearson_hash_engine.sv
// Multi-lane Pearson hash engine with a run-time-loadable 256x8 table.
// Optional build macro PEARSON_SEED_EN adds a per-lane seed port; without
// it lane k starts from h = k.
module pearson_hash_engine
  import pearson_pkg::*;
#(
  parameter int MSG_BYTES = 8,
  parameter int NUM_LANES = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [8*MSG_BYTES-1:0] message,
  output logic                   hash_valid,
  input  logic                   hash_ready,
  output logic [8*NUM_LANES-1:0] hash,
  input  logic                   tbl_we,
  input  logic [7:0]             tbl_addr,
  input  logic [7:0]             tbl_wdata,
  output logic                   tbl_wr_err
`ifdef PEARSON_SEED_EN
  ,
  input  logic [8*NUM_LANES-1:0] seed
`endif
);

  localparam int CNT_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_BYTES - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [8*MSG_BYTES-1:0] msg_q;
  logic [8*MSG_BYTES-1:0] msg_d;
  byte_t                  tbl_q [TBL_DEPTH];
  logic [8*TBL_DEPTH-1:0] tbl_flat_s;
  logic                   tbl_wr_err_q;
  logic                   accept_s;
  logic                   step_s;
  byte_t                  cur_byte_s;
  logic [8*NUM_LANES-1:0] lane_h_s;

  assign accept_s = msg_valid && (state_q == IDLE);
  assign step_s   = (state_q == HASH);

  // FSM next state and byte counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = HASH;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      HASH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (hash_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Message latch: later changes on the input port are ignored.
  always_comb begin
    if (accept_s) begin
      msg_d = message;
    end else begin
      msg_d = msg_q;
    end
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      msg_q        <= {(8*MSG_BYTES){1'b0}};
      tbl_wr_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      msg_q        <= msg_d;
      tbl_wr_err_q <= tbl_we && (state_q != IDLE);
    end
  end

  // Permutation table: identity after reset, writable only while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        tbl_q[i] <= 8'(i);
      end
    end else if (tbl_we && (state_q == IDLE)) begin
      tbl_q[tbl_addr] <= tbl_wdata;
    end
  end

  // Current message byte selected by the counter; byte 0 is hashed first.
  always_comb begin
    cur_byte_s = 8'h00;
    for (int i = 0; i < MSG_BYTES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        cur_byte_s = msg_q[i*8 +: 8];
      end else begin
        cur_byte_s = cur_byte_s;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TBL_DEPTH; gi++) begin : g_tbl_flat
      assign tbl_flat_s[gi*8 +: 8] = tbl_q[gi];
    end

    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0] init_s;
`ifdef PEARSON_SEED_EN
      assign init_s = seed[gi*8 +: 8];
`else
      assign init_s = 8'(gi);
`endif
      pearson_lane u_lane (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (accept_s),
        .step_i     (step_s),
        .init_i     (init_s),
        .msg_byte_i (cur_byte_s),
        .tbl_i      (tbl_flat_s),
        .h_o        (lane_h_s[gi*8 +: 8])
      );
    end
  endgenerate

  assign msg_ready  = (state_q == IDLE);
  assign hash_valid = (state_q == DONE);
  assign hash       = (state_q == DONE) ? lane_h_s : {(8*NUM_LANES){1'b0}};
  assign tbl_wr_err = tbl_wr_err_q;

endmodule

// File: tb/tb_pearson_hash_engine.sv
// Self-checking bench for pearson_hash_engine (8-byte messages, 2 lanes).
module tb_pearson_hash_engine;

  localparam int MB = 8;
  localparam int NL = 2;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            msg_valid;
  logic            msg_ready;
  logic [8*MB-1:0] message;
  logic            hash_valid;
  logic            hash_ready;
  logic [8*NL-1:0] hash;
  logic            tbl_we;
  logic [7:0]      tbl_addr;
  logic [7:0]      tbl_wdata;
  logic            tbl_wr_err;
  logic [8*NL-1:0] seed_v;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl_m [256];

  always #5 clock = ~clock;

  pearson_hash_engine #(.MSG_BYTES(MB), .NUM_LANES(NL)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .message    (message),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .hash       (hash),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .tbl_wr_err (tbl_wr_err)
`ifdef PEARSON_SEED_EN
    ,
    .seed       (seed_v)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference: Pearson hash of each lane, byte 0 first, over the model table.
  function automatic logic [8*NL-1:0] model(input logic [8*MB-1:0] m);
    logic [8*NL-1:0] r;
    logic [7:0]      h;
    r = '0;
    for (int k = 0; k < NL; k++) begin
`ifdef PEARSON_SEED_EN
      h = seed_v[k*8 +: 8];
`else
      h = 8'(k);
`endif
      for (int b = 0; b < MB; b++) h = tbl_m[h ^ m[b*8 +: 8]];
      r[k*8 +: 8] = h;
    end
    return r;
  endfunction

  task automatic identity_model();
    for (int i = 0; i < 256; i++) tbl_m[i] = 8'(i);
  endtask

  task automatic tbl_write(input logic [7:0] a, input logic [7:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    cyc();
    tbl_we = 1'b0;
    tbl_m[a] = d;
    chk("idle_wr_no_err", {63'd0, tbl_wr_err}, 64'd1 - 64'd1);
  endtask

  // One message transaction. wr_at >= 0 injects a (dropped) write at
  // address 8'h08 during HASH; co_we writes along with the accept.
  task automatic run_msg(input logic [8*MB-1:0] m, input int hold, input int wr_at,
                         input logic co_we, input logic [7:0] co_a, input logic [7:0] co_d,
                         input logic [8*NL-1:0] exp);
    int n;
    chk("ready_idle", {63'd0, msg_ready}, 64'd1);
    msg_valid = 1'b1; message = m;
    tbl_we = co_we; tbl_addr = co_a; tbl_wdata = co_d;
    cyc();
    msg_valid = 1'b0; tbl_we = 1'b0;
    message = {$urandom, $urandom};
    chk("busy_not_ready", {63'd0, msg_ready}, 64'd0);
    n = 0;
    while (!hash_valid && n < 20) begin
      if (n == wr_at) begin
        tbl_we = 1'b1; tbl_addr = 8'h08; tbl_wdata = 8'hEE;
      end
      cyc();
      n++;
      tbl_we = 1'b0;
      if (wr_at >= 0 && n == wr_at + 1) chk("wr_err_pulse", {63'd0, tbl_wr_err}, 64'd1);
      if (wr_at >= 0 && n == wr_at + 2) chk("wr_err_single", {63'd0, tbl_wr_err}, 64'd0);
    end
    chk("latency", 64'(n), 64'(MB));
    chk("hash", 64'(hash), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("hold_hash", 64'(hash), 64'(exp));
      chk("hold_valid", {63'd0, hash_valid}, 64'd1);
      chk("hold_not_ready", {63'd0, msg_ready}, 64'd0);
    end
    hash_ready = 1'b1;
    cyc();
    hash_ready = 1'b0;
    chk("post_ready", {63'd0, msg_ready}, 64'd1);
    chk("post_valid", {63'd0, hash_valid}, 64'd0);
    chk("post_hash_zero", 64'(hash), 64'd0);
  endtask

  logic [8*MB-1:0] rm;
  logic [8*NL-1:0] exp_v;
  logic [7:0]      ca, cd;
  logic            cw;

  initial begin
    reset_n = 1'b0; msg_valid = 1'b0; message = '0; hash_ready = 1'b0;
    tbl_we = 1'b0; tbl_addr = 8'h00; tbl_wdata = 8'h00; seed_v = 16'h0100;
    identity_model();
    repeat (3) cyc();
    chk("rst_ready", {63'd0, msg_ready}, 64'd1);
    chk("rst_valid", {63'd0, hash_valid}, 64'd0);
    chk("rst_hash", 64'(hash), 64'd0);
    chk("rst_wr_err", {63'd0, tbl_wr_err}, 64'd0);
    reset_n = 1'b1;
    cyc();

    // Known vector with identity table, then held result.
`ifdef PEARSON_SEED_EN
    seed_v = 16'h01FF;
    exp_v  = 16'h09F7;
`else
    exp_v  = 16'h0908;
`endif
    run_msg(64'h0102030405060708, 0, -1, 1'b0, 8'h00, 8'h00, exp_v);
    run_msg(64'h0102030405060708, 5, -1, 1'b0, 8'h00, 8'h00, exp_v);

    // Idle table write, then a dropped write during HASH.
    tbl_write(8'h00, 8'h5A);
`ifdef PEARSON_SEED_EN
    exp_v = model(64'h0);
`else
    exp_v = 16'h015A;
`endif
    run_msg(64'h0, 0, 2, 1'b0, 8'h00, 8'h00, exp_v);
`ifdef PEARSON_SEED_EN
    exp_v = model(64'h0102030405060708);
`else
    exp_v = 16'h0908;
`endif
    run_msg(64'h0102030405060708, 0, -1, 1'b0, 8'h00, 8'h00, exp_v);

    // Reset in the middle of HASH (cnt == 3).
    msg_valid = 1'b1; message = 64'h1122334455667788;
    cyc();
    msg_valid = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, msg_ready}, 64'd1);
    chk("midrst_valid", {63'd0, hash_valid}, 64'd0);
    chk("midrst_hash", 64'(hash), 64'd0);
    cyc();
    reset_n = 1'b1;
    identity_model();
    cyc();
`ifdef PEARSON_SEED_EN
    exp_v = model(64'h0);
`else
    exp_v = 16'h0100;
`endif
    run_msg(64'h0, 0, -1, 1'b0, 8'h00, 8'h00, exp_v);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 30; it++) begin
`ifdef PEARSON_SEED_EN
      seed_v = 16'($urandom);
`endif
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        tbl_write(8'($urandom), 8'($urandom));
      end
      rm = {$urandom, $urandom};
      cw = 1'($urandom);
      ca = 8'($urandom);
      cd = 8'($urandom);
      if (cw) tbl_m[ca] = cd;
      exp_v = model(rm);
      run_msg(rm, int'($urandom_range(0, 3)), (it % 4 == 0) ? int'($urandom_range(0, 6)) : -1,
              cw, ca, cd, exp_v);
      if (it % 4 == 0) begin
        // Verify the dropped write at 8'h08 left the table alone.
        rm = {56'h0, 8'h08};
        exp_v = model(rm);
        run_msg(rm, 0, -1, 1'b0, 8'h00, 8'h00, exp_v);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
